// File: rtl/adc_capture_pkg.sv
// Shared types for the scope capture controller: FSM states and mode encodings.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWaitTrig,
    StPost,
    StDone,
    StDump
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_NORM   = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_SINGLE = 2'b11;

endpackage

// File: rtl/capture_decimator.sv
// Sample decimator: keeps one of every 2**i_decimator ADC strobes.
module capture_decimator
  import adc_capture_pkg::*;
#(
  parameter int unsigned DEC_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_smpl_vld,
  input  logic             i_clr,
  input  logic [DEC_W-1:0] i_decimator,
  output logic             o_keep
);

  localparam int unsigned CntW = (2 ** DEC_W) - 1;

  logic [CntW-1:0] r_dec_cnt;
  logic [CntW-1:0] w_limit;

  // Terminal count 2**decimator - 1, built as a low-bit mask.
  assign w_limit = ~({CntW{1'b1}} << i_decimator);
  assign o_keep  = i_smpl_vld & (r_dec_cnt == w_limit);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_dec_cnt <= '0;
    end else if (o_keep) begin
      r_dec_cnt <= '0;
    end else if (i_smpl_vld) begin
      r_dec_cnt <= r_dec_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture controller: circular trace writes with pre/post-trigger framing and paced dump.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEC_W  = 4,
  parameter int unsigned AUTO_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_smpl_vld,
  input  logic              i_trig,
  input  logic [1:0]        i_mode,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_trig_pos,
  input  logic [DEC_W-1:0]  i_decimator,
  input  logic [AUTO_W-1:0] i_auto_to,
  input  logic              i_clr_cap_done,
  input  logic              i_dump_req,
  input  logic              i_dump_rdy,
  output logic              o_armed,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_rd_en,
  output logic              o_capture_done,
  output logic [ADDR_W-1:0] o_trace_end,
  output logic              o_dump_fin
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t              r_state, w_state_d;
  logic [ADDR_W:0]     r_smpl_cnt;
  logic [ADDR_W-1:0]   r_post_cnt;
  logic [AUTO_W-1:0]   r_auto_cnt;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W-1:0]   r_raddr;
  logic [ADDR_W-1:0]   r_rd_cnt;
  logic [ADDR_W-1:0]   r_trace_end;
  logic                r_capture_done;
  logic                r_dump_fin;

  logic w_keep, w_cap, w_armed, w_trig_fire, w_post_keep, w_last;
  logic w_rd, w_rd_last, w_arm, w_set_done, w_dump_go;

  capture_decimator #(
    .DEC_W(DEC_W)
  ) u_decimator (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_smpl_vld (i_smpl_vld),
    .i_clr      (w_arm),
    .i_decimator(i_decimator),
    .o_keep     (w_keep)
  );

  assign w_cap   = (r_state == StFill) || (r_state == StWaitTrig) || (r_state == StPost);
  assign w_armed = ({1'b0, r_smpl_cnt} + {2'b00, i_trig_pos}) >= (ADDR_W + 2)'(DEPTH);

  assign w_trig_fire = i_trig ||
                       ((i_mode == MODE_AUTO) && w_keep && (r_auto_cnt == i_auto_to));
  // The trigger-cycle sample counts as the first post-trigger sample.
  assign w_post_keep = w_keep &&
                       ((r_state == StPost) || ((r_state == StWaitTrig) && w_trig_fire));
  assign w_last      = w_post_keep && (r_post_cnt == i_trig_pos);

  assign w_rd      = (r_state == StDump) && i_dump_rdy;
  assign w_rd_last = w_rd && (r_rd_cnt == {ADDR_W{1'b1}});
  assign w_dump_go = (r_state == StDone) && i_dump_req;

  always_comb begin
    w_state_d  = r_state;
    w_arm      = 1'b0;
    w_set_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && (i_mode != MODE_OFF) && !r_capture_done) begin
          w_state_d = StFill;
          w_arm     = 1'b1;
        end
      end
      StFill: begin
        if (i_mode == MODE_OFF) w_state_d = StIdle;
        else if (w_armed)       w_state_d = StWaitTrig;
      end
      StWaitTrig, StPost: begin
        if (i_mode == MODE_OFF) begin
          w_state_d = StIdle;
        end else if (w_last) begin
          w_state_d  = StDone;
          w_set_done = 1'b1;
        end else if (w_trig_fire) begin
          w_state_d = StPost;
        end
      end
      StDone: begin
        if (i_dump_req) begin
          w_state_d = StDump;
        end else if (i_clr_cap_done) begin
          if ((i_mode == MODE_NORM) || (i_mode == MODE_AUTO)) begin
            w_state_d = StFill;
            w_arm     = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StDump: begin
        if (w_rd_last) w_state_d = StDone;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_smpl_cnt     <= '0;
      r_post_cnt     <= '0;
      r_auto_cnt     <= '0;
      r_waddr        <= '0;
      r_raddr        <= '0;
      r_rd_cnt       <= '0;
      r_trace_end    <= '0;
      r_capture_done <= 1'b0;
      r_dump_fin     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_dump_fin <= w_rd_last;

      // Write pointer is never rewound, so the trace stays circular across captures.
      if (o_we) r_waddr <= r_waddr + ADDR_W'(1);

      if (w_arm) begin
        r_smpl_cnt <= '0;
        r_post_cnt <= '0;
        r_auto_cnt <= '0;
      end else begin
        if (o_we && (r_smpl_cnt != (ADDR_W + 1)'(DEPTH))) r_smpl_cnt <= r_smpl_cnt + (ADDR_W + 1)'(1);
        if (w_post_keep) r_post_cnt <= r_post_cnt + ADDR_W'(1);
        if ((r_state == StWaitTrig) && w_keep) r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
      end

      if (w_set_done) begin
        r_capture_done <= 1'b1;
        r_trace_end    <= r_waddr;
      end else if (i_clr_cap_done && !w_dump_go) begin
        r_capture_done <= 1'b0;
      end

      if (w_dump_go) begin
        r_raddr  <= r_trace_end + ADDR_W'(1);
        r_rd_cnt <= '0;
      end else if (w_rd) begin
        r_raddr  <= r_raddr + ADDR_W'(1);
        r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      end
    end
  end

  assign o_armed        = w_armed;
  assign o_we           = w_keep && w_cap;
  assign o_waddr        = r_waddr;
  assign o_raddr        = r_raddr;
  assign o_rd_en        = w_rd;
  assign o_capture_done = r_capture_done;
  assign o_trace_end    = r_trace_end;
  assign o_dump_fin     = r_dump_fin;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl with a read-address scoreboard.
module tb_adc_capture_ctrl;

  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, smpl_vld, trig, start, clr_cap_done, dump_req, dump_rdy;
  logic [1:0]    mode;
  logic [AW-1:0] trig_pos;
  logic [3:0]    decimator;
  logic [15:0]   auto_to;
  logic          armed, we, rd_en, capture_done, dump_fin;
  logic [AW-1:0] waddr, raddr, trace_end;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int fin_cnt = 0;
  int exp_waddr = 0;
  int snap;
  int rd_q[$];

  adc_capture_ctrl #(
    .ADDR_W(AW),
    .DEC_W (4),
    .AUTO_W(16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_smpl_vld    (smpl_vld),
    .i_trig        (trig),
    .i_mode        (mode),
    .i_start       (start),
    .i_trig_pos    (trig_pos),
    .i_decimator   (decimator),
    .i_auto_to     (auto_to),
    .i_clr_cap_done(clr_cap_done),
    .i_dump_req    (dump_req),
    .i_dump_rdy    (dump_rdy),
    .o_armed       (armed),
    .o_we          (we),
    .o_waddr       (waddr),
    .o_raddr       (raddr),
    .o_rd_en       (rd_en),
    .o_capture_done(capture_done),
    .o_trace_end   (trace_end),
    .o_dump_fin    (dump_fin)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic t);
    smpl_vld = 1'b1;
    trig     = t;
    tick();
    smpl_vld = 1'b0;
    trig     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cap_done = 1'b1;
    tick();
    clr_cap_done = 1'b0;
  endtask

  task automatic check_all_zero();
    check_eq("z_armed", int'(armed), 0);
    check_eq("z_we", int'(we), 0);
    check_eq("z_waddr", int'(waddr), 0);
    check_eq("z_raddr", int'(raddr), 0);
    check_eq("z_rd_en", int'(rd_en), 0);
    check_eq("z_capture_done", int'(capture_done), 0);
    check_eq("z_trace_end", int'(trace_end), 0);
    check_eq("z_dump_fin", int'(dump_fin), 0);
  endtask

  // Monitor: write-address model and read-address scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_waddr = 0;
      end else begin
        if (we) begin
          check_eq("waddr", int'(waddr), exp_waddr);
          exp_waddr = (exp_waddr + 1) % DEPTH;
          wr_cnt++;
        end
        if (rd_en) begin
          if (rd_q.size() == 0) check_eq("rd_extra", int'(rd_en), 0);
          else check_eq("raddr", int'(raddr), rd_q.pop_front());
          rd_cnt++;
        end
        if (dump_fin) fin_cnt++;
      end
    end
  end

  initial begin
    rst = 1'b1; smpl_vld = 1'b0; trig = 1'b0; start = 1'b0; clr_cap_done = 1'b0;
    dump_req = 1'b0; dump_rdy = 1'b0; mode = 2'b00; trig_pos = '0; decimator = '0;
    auto_to = '0;
    tick();
    tick();
    check_all_zero();
    rst = 1'b0;
    tick();

    // Normal capture: trig ignored in FILL, real trig on strobe 20.
    mode = 2'b01; trig_pos = 4'd4;
    pulse_start();
    snap = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 20) snap = wr_cnt;
      strobe((i == 5) || (i == 20));
      if (i == 11) check_eq("armed_early", int'(armed), 0);
      if (i == 12) check_eq("armed_at_12", int'(armed), 1);
      if (i == 23) check_eq("done_early", int'(capture_done), 0);
      if (i == 24) check_eq("done_set", int'(capture_done), 1);
    end
    repeat (4) strobe(1'b0);
    check_eq("writes_from_trig", wr_cnt - snap, 5);
    check_eq("total_writes", wr_cnt, 24);
    check_eq("trace_end", int'(trace_end), 7);

    // Dump with dump_rdy toggling.
    for (int k = 1; k <= DEPTH; k++) rd_q.push_back((7 + k) % DEPTH);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int c = 0; c < 200; c++) begin
      dump_rdy = c[0];
      @(negedge clk);
      #1;
      if (fin_cnt != 0) break;
      @(posedge clk);
      #1;
    end
    dump_rdy = 1'b0;
    repeat (4) tick();
    check_eq("dump_reads", rd_cnt, 16);
    check_eq("dump_fin_once", fin_cnt, 1);
    check_eq("dump_q_empty", rd_q.size(), 0);
    check_eq("done_after_dump", int'(capture_done), 1);

    // Single-shot returns to IDLE after the acknowledge.
    mode = 2'b11;
    pulse_clr();
    check_eq("clr_done", int'(capture_done), 0);
    snap = wr_cnt;
    repeat (10) strobe(1'b0);
    check_eq("single_idle_no_wr", wr_cnt - snap, 0);

    // Decimation by 8.
    decimator = 4'd3; trig_pos = 4'd12;
    pulse_start();
    snap = wr_cnt;
    for (int i = 0; i < 64; i++) begin
      smpl_vld = 1'b1;
      @(negedge clk);
      #1;
      check_eq("dec_we", int'(we), int'((i % 8) == 7));
      @(posedge clk);
      #1;
    end
    smpl_vld = 1'b0;
    check_eq("dec_writes", wr_cnt - snap, 8);
    mode = 2'b00;
    tick();
    snap = wr_cnt;
    repeat (16) strobe(1'b0);
    check_eq("off_no_wr", wr_cnt - snap, 0);

    // Auto-roll without trigger.
    decimator = 4'd0; mode = 2'b10; auto_to = 16'd5; trig_pos = 4'd2;
    pulse_start();
    snap = wr_cnt;
    for (int i = 1; i <= 23; i++) begin
      strobe(1'b0);
      if (i == 22) check_eq("auto_done_early", int'(capture_done), 0);
      if (i == 23) check_eq("auto_done", int'(capture_done), 1);
    end
    repeat (3) strobe(1'b0);
    check_eq("auto_writes", wr_cnt - snap, 23);

    // Mode 01 re-arms into FILL, then reset lands mid-POST.
    mode = 2'b01; trig_pos = 4'd4;
    pulse_clr();
    check_eq("rearm_clr", int'(capture_done), 0);
    snap = wr_cnt;
    for (int i = 1; i <= 17; i++) strobe(i == 16);
    check_eq("rearm_writes", wr_cnt - snap, 17);
    check_eq("rearm_not_done", int'(capture_done), 0);
    rst = 1'b1;
    tick();
    check_all_zero();
    rst = 1'b0;
    tick();

    // trig_pos = 0 ends on the trigger sample.
    trig_pos = 4'd0;
    pulse_start();
    snap = wr_cnt;
    for (int i = 1; i <= 21; i++) begin
      strobe(i == 21);
      if (i == 20) check_eq("tp0_done_early", int'(capture_done), 0);
      if (i == 21) check_eq("tp0_done", int'(capture_done), 1);
    end
    check_eq("tp0_trace_end", int'(trace_end), 4);
    repeat (3) strobe(1'b0);
    check_eq("tp0_writes", wr_cnt - snap, 21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
